motor_pwm_sequencer: RTL

MOTOR_PWM_SEQUENCER -- requirements
Module: motor_pwm_sequencer

---
 rtl/motor_pwm_pkg.sv | 20 ++
 rtl/pwm_channel.sv | 46 ++++
 rtl/motor_pwm_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/motor_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_pkg
// Brief    : Shared fetch-state encoding and RAM interface constants for the
//            motor PWM sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package motor_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_RD_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Brief    : One motor channel: active pulse-width register plus registered
//            compare output, aligned to the next-cycle frame counter value.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_width,
    input  logic             i_run_nxt,
    input  logic [CNT_W-1:0] i_cnt_nxt,
    output logic             o_pwm
);

    logic [CNT_W-1:0] r_width;
    logic             r_pwm;
    logic [CNT_W-1:0] w_width_nxt;

    // Compare against next-cycle values so the registered pulse lines up with cnt
    assign w_width_nxt = i_load ? i_width : r_width;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_width <= '0;
            r_pwm   <= 1'b0;
        end else if (i_clear) begin
            r_width <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_width <= w_width_nxt;
            r_pwm   <= i_run_nxt && (i_cnt_nxt < w_width_nxt);
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/motor_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_sequencer
// Brief    : Frame-based multi-channel motor PWM; pulse widths are fetched from
//            on-chip RAM each frame and applied in the following frame.
// Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_sequencer
    import motor_pwm_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int PERIOD_CYC = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  stop,
    input  logic [RAM_ADDR_W-1:0] base_addr,
    output logic [RAM_ADDR_W-1:0] ram_address,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic                  ram_clken,
    input  logic [31:0]           ram_readdata,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  frame_tick,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] c_PERIOD   = CNT_W'(PERIOD_CYC);
    localparam logic [2:0]       c_LAST_IDX = 3'(NUM_CH - 1);

    generate
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("NUM_CH must be within 1..8");
        end
        if (NUM_CH + 2 >= PERIOD_CYC) begin : g_bad_period
            $error("NUM_CH+2 must be less than PERIOD_CYC");
        end
        if ((64'd1 << CNT_W) <= 64'(PERIOD_CYC)) begin : g_bad_cnt_w
            $error("CNT_W too narrow for PERIOD_CYC");
        end
        if (RAM_RD_LAT != 1) begin : g_bad_latency
            $error("capture pipeline assumes a one-cycle RAM read latency");
        end
    endgenerate

    logic             r_running;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_boundary;
    logic             w_run_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_frame_start;

    assign w_boundary = r_running && (r_cnt == c_LAST_CNT);

    always_comb begin
        w_run_nxt = r_running;
        w_cnt_nxt = r_cnt;
        if (stop) begin
            w_run_nxt = 1'b0;
            w_cnt_nxt = '0;
        end else if (!r_running || w_boundary) begin
            w_run_nxt = enable;
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    assign w_frame_start = w_run_nxt && (w_cnt_nxt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_running <= w_run_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tick    <= w_frame_start;
        end
    end

    fetch_state_t             r_state;
    logic [2:0]               r_idx;
    logic [RAM_ADDR_W-1:0]    r_base;
    logic                     r_cap_vld;
    logic [2:0]               r_cap_idx;
    logic [CNT_W-1:0]         r_shadow [NUM_CH];
    logic [CNT_W-1:0]         w_rd_width;
    logic                     w_unused_rd;

    assign w_rd_width  = (ram_readdata[CNT_W-1:0] > c_PERIOD) ? c_PERIOD
                                                               : ram_readdata[CNT_W-1:0];
    assign w_unused_rd = ^ram_readdata[31:CNT_W];

    // Word for the address issued last cycle arrives now; r_cap_* tracks it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_base         <= '0;
            ram_address    <= '0;
            ram_chipselect <= 1'b0;
            r_cap_vld      <= 1'b0;
            r_cap_idx      <= '0;
            for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
        end else if (stop) begin
            r_state        <= IDLE;
            ram_chipselect <= 1'b0;
            r_cap_vld      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
        end else begin
            r_cap_vld <= (r_state == FETCH);
            r_cap_idx <= r_idx;
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_cap_vld && (r_cap_idx == 3'(i))) r_shadow[i] <= w_rd_width;
            end
            case (r_state)
                IDLE: begin
                    if (w_frame_start) begin
                        r_state        <= FETCH;
                        r_idx          <= '0;
                        r_base         <= base_addr;
                        ram_address    <= base_addr;
                        ram_chipselect <= 1'b1;
                    end
                end
                FETCH: begin
                    if (r_idx == c_LAST_IDX) begin
                        r_state        <= DRAIN;
                        ram_chipselect <= 1'b0;
                    end else begin
                        r_idx       <= r_idx + 3'd1;
                        ram_address <= r_base + RAM_ADDR_W'(r_idx) + 12'd1;
                    end
                end
                DRAIN:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Leaving run at a boundary loads zeros so a later restart begins all-low
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic [CNT_W-1:0] w_load_width;
            assign w_load_width = w_run_nxt ? r_shadow[g] : '0;
            pwm_channel #(
                .CNT_W (CNT_W)
            ) u_pwm_channel (
                .clk       (clk),
                .reset_n   (reset_n),
                .i_clear   (stop),
                .i_load    (w_boundary),
                .i_width   (w_load_width),
                .i_run_nxt (w_run_nxt),
                .i_cnt_nxt (w_cnt_nxt),
                .o_pwm     (pwm_out[g])
            );
        end
    endgenerate

    assign frame_tick = r_tick;
    assign busy       = (r_state != IDLE);
    assign ram_write  = 1'b0;
    assign ram_clken  = 1'b1;

endmodule
`default_nettype wire
